zet_fetch_gather: RTL and testbench

Front-end stage directly upstream of the instruction decoder. Buffers the incoming instruction byte stream in a small FIFO and walks each instruction's bytes in order: prefixes, opcode, ModR/M, displacement, immediate. It consumes the decoder's combinational need_modrm/need_off/need_imm/off_size/imm_size answers and presents a complete instruction (opcode, modrm, off, imm, rep, sop_l, length) with a valid/ack handshake.

---
 rtl/zet_fetch_gather_if.sv | 37 +++
 rtl/zet_fetch_gather.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_zet_fetch_gather.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zet_fetch_gather_if.sv
// Byte-stream, decoder-query and instruction-delivery signals of zet_fetch_gather.
// master = the gather stage, slave = its surroundings (prefetcher, decoder, consumer).
interface zet_fetch_gather_if;
  logic [7:0]  byte_in;
  logic        byte_vld;
  logic        byte_rdy;
  logic        flush;
  logic        need_modrm;
  logic        need_off;
  logic        need_imm;
  logic        off_size;
  logic        imm_size;
  logic [7:0]  opcode;
  logic [7:0]  modrm;
  logic [15:0] off;
  logic [15:0] imm;
  logic        rep;
  logic [2:0]  sop_l;
  logic        lock;
  logic [3:0]  ilen;
  logic        instr_vld;
  logic        instr_ack;

  modport master (
    input  byte_in, byte_vld, flush,
    input  need_modrm, need_off, need_imm, off_size, imm_size,
    input  instr_ack,
    output byte_rdy, opcode, modrm, off, imm, rep, sop_l, lock, ilen, instr_vld
  );

  modport slave (
    output byte_in, byte_vld, flush,
    output need_modrm, need_off, need_imm, off_size, imm_size,
    output instr_ack,
    input  byte_rdy, opcode, modrm, off, imm, rep, sop_l, lock, ilen, instr_vld
  );
endinterface

// File: rtl/zet_fetch_gather.sv
// Instruction byte FIFO plus gather FSM (prefixes, opcode, ModR/M, disp, imm) ahead of the decoder.
// Define ZET_FETCH_LOCK_EN to treat F0 as a LOCK prefix; otherwise F0 is an ordinary opcode.
module zet_fetch_gather #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic                clk,
  input logic                rst,
  zet_fetch_gather_if.master bus
);

  typedef enum logic [2:0] {
    S_PFX,
    S_MODRM,
    S_CHK,
    S_OFF0,
    S_OFF1,
    S_IMM0,
    S_IMM1,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  logic [7:0]  opcode_reg;
  logic [7:0]  modrm_reg;
  logic [15:0] off_reg;
  logic [15:0] imm_reg;
  logic        rep_reg;
  logic [2:0]  sop_reg;
  logic [3:0]  ilen_reg;
  logic        need_imm_reg;
  logic        off_size_reg;
  logic        imm_size_reg;

  logic head_rep;
  logic head_seg;
  logic head_lock;
  logic head_pfx;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign head  = mem[rd_ptr_reg];
  // A flushed cycle drops the incoming byte along with everything already queued.
  assign push  = bus.byte_vld && !full && !bus.flush;

  assign bus.byte_rdy = !full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.byte_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (bus.flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_rep = (head == 8'hF2) || (head == 8'hF3);
  assign head_seg = (head == 8'h26) || (head == 8'h2E) || (head == 8'h36) || (head == 8'h3E);
`ifdef ZET_FETCH_LOCK_EN
  assign head_lock = (head == 8'hF0);
`else
  assign head_lock = 1'b0;
`endif
  assign head_pfx = head_rep || head_seg || head_lock;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_PFX;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      S_PFX: begin
        if (!empty) begin
          pop = 1'b1;
          if (!head_pfx) begin
            state_next = S_MODRM;
          end
        end
      end
      S_MODRM: begin
        if (bus.need_modrm) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = S_CHK;
          end
        end else begin
          state_next = S_CHK;
        end
      end
      // Non-consuming: lets the decoder answer from the final modrm value.
      S_CHK: begin
        if (bus.need_off) begin
          state_next = S_OFF0;
        end else if (bus.need_imm) begin
          state_next = S_IMM0;
        end else begin
          state_next = S_DONE;
        end
      end
      S_OFF0: begin
        if (!empty) begin
          pop = 1'b1;
          if (off_size_reg) begin
            state_next = S_OFF1;
          end else if (need_imm_reg) begin
            state_next = S_IMM0;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_OFF1: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = need_imm_reg ? S_IMM0 : S_DONE;
        end
      end
      S_IMM0: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = imm_size_reg ? S_IMM1 : S_DONE;
        end
      end
      S_IMM1: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.instr_ack) begin
          state_next = S_PFX;
        end
      end
      default: state_next = S_PFX;
    endcase
    if (bus.flush) begin
      state_next = S_PFX;
      pop        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode_reg   <= '0;
      modrm_reg    <= '0;
      off_reg      <= '0;
      imm_reg      <= '0;
      rep_reg      <= 1'b0;
      sop_reg      <= '0;
      ilen_reg     <= '0;
      need_imm_reg <= 1'b0;
      off_size_reg <= 1'b0;
      imm_size_reg <= 1'b0;
    end else if (bus.flush) begin
      modrm_reg    <= '0;
      off_reg      <= '0;
      imm_reg      <= '0;
      rep_reg      <= 1'b0;
      sop_reg      <= '0;
      ilen_reg     <= '0;
      need_imm_reg <= 1'b0;
      off_size_reg <= 1'b0;
      imm_size_reg <= 1'b0;
    end else begin
      if (pop && (ilen_reg != 4'd15)) begin
        ilen_reg <= ilen_reg + 4'd1;
      end
      case (state_reg)
        S_PFX: begin
          if (pop) begin
            if (head_rep) begin
              rep_reg <= 1'b1;
            end else if (head_seg) begin
              sop_reg <= {1'b1, head[4:3]};
            end else if (!head_lock) begin
              opcode_reg <= head;
            end
          end
        end
        S_MODRM: begin
          if (pop) begin
            modrm_reg <= head;
          end
        end
        S_CHK: begin
          need_imm_reg <= bus.need_imm;
          off_size_reg <= bus.off_size;
          imm_size_reg <= bus.imm_size;
        end
        S_OFF0: begin
          if (pop) begin
            off_reg[7:0] <= head;
            if (!off_size_reg) begin
              off_reg[15:8] <= {8{head[7]}};
            end
          end
        end
        S_OFF1: begin
          if (pop) begin
            off_reg[15:8] <= head;
          end
        end
        S_IMM0: begin
          if (pop) begin
            imm_reg[7:0] <= head;
            if (!imm_size_reg) begin
              imm_reg[15:8] <= {8{head[7]}};
            end
          end
        end
        S_IMM1: begin
          if (pop) begin
            imm_reg[15:8] <= head;
          end
        end
        S_DONE: begin
          // opcode deliberately survives the ack; everything else restarts clean.
          if (bus.instr_ack) begin
            modrm_reg <= '0;
            off_reg   <= '0;
            imm_reg   <= '0;
            rep_reg   <= 1'b0;
            sop_reg   <= '0;
            ilen_reg  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ZET_FETCH_LOCK_EN
  logic lock_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_reg <= 1'b0;
    end else if (bus.flush) begin
      lock_reg <= 1'b0;
    end else if ((state_reg == S_PFX) && pop && head_lock) begin
      lock_reg <= 1'b1;
    end else if ((state_reg == S_DONE) && bus.instr_ack) begin
      lock_reg <= 1'b0;
    end
  end

  assign bus.lock = lock_reg;
`else
  assign bus.lock = 1'b0;
`endif

  assign bus.opcode    = opcode_reg;
  assign bus.modrm     = modrm_reg;
  assign bus.off       = off_reg;
  assign bus.imm       = imm_reg;
  assign bus.rep       = rep_reg;
  assign bus.sop_l     = sop_reg;
  assign bus.ilen      = ilen_reg;
  assign bus.instr_vld = (state_reg == S_DONE);

endmodule

// File: tb/tb_zet_fetch_gather.sv
// Randomized bench for zet_fetch_gather: byte-stream parser model, decoder stub, scoreboard.
`timescale 1ns/1ps
module tb_zet_fetch_gather;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  modrm;
    logic [15:0] off;
    logic [15:0] imm;
    logic        rep;
    logic [2:0]  sop;
    logic        lock;
    logic [3:0]  ilen;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  zet_fetch_gather_if bus ();

  zet_fetch_gather #(.DEPTH(DEPTH), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int ack_mode = 0;   // 0 never, 1 random, 2 immediately
  int vld_pct  = 100;
  logic [7:0] tx_q[$];
  instr_t     exp_q[$];

  // Decoder stub; returns {need_modrm, need_off, off_size, need_imm, imm_size}.
  function automatic logic [4:0] dec(input logic [7:0] op, input logic [7:0] mr);
    logic nm, no, os, ni, isz;
    logic [1:0] md;
    md = mr[7:6];
    case (op)
      8'h88, 8'h89, 8'h8A, 8'h8B: begin nm = 1'b1; ni = 1'b0; isz = 1'b0; end
      8'hC6:                      begin nm = 1'b1; ni = 1'b1; isz = 1'b0; end
      8'hC7:                      begin nm = 1'b1; ni = 1'b1; isz = 1'b1; end
      8'h90, 8'hA5:               begin nm = 1'b0; ni = 1'b0; isz = 1'b0; end
      default:                    begin nm = op[0]; ni = op[3]; isz = op[4]; end
    endcase
    if (nm) begin
      no = (md == 2'd1) || (md == 2'd2) || ((md == 2'd0) && (mr[2:0] == 3'd6));
      os = (md != 2'd1);
    end else begin
      no = op[1];
      os = op[2];
    end
    return {nm, no, os, ni, isz};
  endfunction

  assign {bus.need_modrm, bus.need_off, bus.off_size, bus.need_imm, bus.imm_size} =
      dec(bus.opcode, bus.modrm);

  function automatic instr_t mk(input logic [7:0] op, input logic [7:0] mr, input logic [15:0] o,
                                input logic [15:0] im, input logic rp, input logic [2:0] sp,
                                input logic lk, input logic [3:0] il);
    instr_t e;
    e.opcode = op; e.modrm = mr; e.off = o; e.imm = im;
    e.rep = rp; e.sop = sp; e.lock = lk; e.ilen = il;
    return e;
  endfunction

  function automatic bit is_pfx(input logic [7:0] b);
`ifdef ZET_FETCH_LOCK_EN
    if (b == 8'hF0) return 1'b1;
`endif
    return (b == 8'hF2) || (b == 8'hF3) || (b == 8'h26) || (b == 8'h2E) ||
           (b == 8'h36) || (b == 8'h3E);
  endfunction

  // Reference: parse one instruction from the front of a byte list.
  function automatic instr_t model_parse(input logic [7:0] b[$]);
    instr_t e;
    int i;
    logic [4:0] d;
    logic [7:0] lo;
    e = '0;
    i = 0;
    while (is_pfx(b[i])) begin
      case (b[i])
        8'hF2, 8'hF3: e.rep = 1'b1;
        8'h26: e.sop = 3'b100;
        8'h2E: e.sop = 3'b101;
        8'h36: e.sop = 3'b110;
        8'h3E: e.sop = 3'b111;
        default: e.lock = 1'b1;
      endcase
      i++;
    end
    e.opcode = b[i];
    i++;
    d = dec(e.opcode, 8'h00);
    if (d[4]) begin e.modrm = b[i]; i++; end
    d = dec(e.opcode, e.modrm);
    if (d[3]) begin
      lo = b[i];
      if (d[2]) begin e.off = {b[i+1], lo}; i += 2; end
      else      begin e.off = {{8{lo[7]}}, lo}; i += 1; end
    end
    if (d[1]) begin
      lo = b[i];
      if (d[0]) begin e.imm = {b[i+1], lo}; i += 2; end
      else      begin e.imm = {{8{lo[7]}}, lo}; i += 1; end
    end
    e.ilen = (i > 15) ? 4'd15 : 4'(i);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk_instr(input string name, input instr_t a, input instr_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got op=%h mrm=%h off=%h imm=%h rep=%b sop=%b lock=%b ilen=%0d expected op=%h mrm=%h off=%h imm=%h rep=%b sop=%b lock=%b ilen=%0d",
               name, a.opcode, a.modrm, a.off, a.imm, a.rep, a.sop, a.lock, a.ilen,
               e.opcode, e.modrm, e.off, e.imm, e.rep, e.sop, e.lock, e.ilen);
    end
  endtask

  task automatic push_exp(input logic [7:0] b[$], input instr_t e);
    foreach (b[k]) tx_q.push_back(b[k]);
    exp_q.push_back(e);
  endtask

  function automatic instr_t dut_instr();
    return mk(bus.opcode, bus.modrm, bus.off, bus.imm, bus.rep, bus.sop_l, bus.lock, bus.ilen);
  endfunction

  // Compare process: checks every valid cycle, owns instr_ack.
  initial begin
    logic ack, ack_prev;
    instr_t a;
    bus.instr_ack = 1'b0;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      if (rst) begin
        if (ack_prev) begin
          chk("ack_clear", {bus.rep, bus.sop_l, bus.lock, bus.modrm, bus.off, bus.imm,
                            bus.ilen, bus.instr_vld}, 64'd0);
        end
        if (bus.instr_vld) begin
          a = dut_instr();
          if (exp_q.size() == 0) begin
            chk("unexpected_instr", 64'(a), 64'd0);
            ack = 1'b1;
          end else begin
            chk_instr("instr", a, exp_q[0]);
            if (ack_mode == 2 || (ack_mode == 1 && $urandom_range(0, 3) == 0)) begin
              ack = 1'b1;
              $display("instr op=%h mrm=%h off=%h imm=%h rep=%b sop=%b lock=%b ilen=%0d",
                       a.opcode, a.modrm, a.off, a.imm, a.rep, a.sop, a.lock, a.ilen);
              void'(exp_q.pop_front());
            end
          end
        end
      end
      bus.instr_ack = ack;
      ack_prev = ack;
    end
  end

  task automatic cycle();
    @(negedge clk);
    #2;
    if (tx_q.size() > 0 && $urandom_range(0, 99) < vld_pct) begin
      bus.byte_vld = 1'b1;
      bus.byte_in  = tx_q[0];
      if (bus.byte_rdy) void'(tx_q.pop_front());
    end else begin
      bus.byte_vld = 1'b0;
      bus.byte_in  = 8'($urandom);
    end
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while ((tx_q.size() > 0 || exp_q.size() > 0) && n < limit) begin
      cycle();
      n++;
    end
    chk(name, 64'(tx_q.size() + exp_q.size()), 64'd0);
  endtask

  function automatic logic [7:0] pick_pfx();
    logic [7:0] t [0:6];
    t = '{8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0};
`ifdef ZET_FETCH_LOCK_EN
    return t[$urandom_range(0, 6)];
`else
    return t[$urandom_range(0, 5)];
`endif
  endfunction

  task automatic gen_instr();
    logic [7:0] b[$];
    int np;
    logic [7:0] op, mr;
    logic [4:0] d;
    np = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 16) : $urandom_range(0, 3);
    for (int k = 0; k < np; k++) b.push_back(pick_pfx());
    op = 8'($urandom);
    while (is_pfx(op) || op == 8'hF0) op = 8'($urandom);
    b.push_back(op);
    mr = 8'h00;
    d = dec(op, mr);
    if (d[4]) begin mr = 8'($urandom); b.push_back(mr); end
    d = dec(op, mr);
    if (d[3]) begin b.push_back(8'($urandom)); if (d[2]) b.push_back(8'($urandom)); end
    if (d[1]) begin b.push_back(8'($urandom)); if (d[0]) b.push_back(8'($urandom)); end
    push_exp(b, model_parse(b));
  endtask

  initial begin
    logic [7:0] q[$];
    int n;
    bus.byte_vld = 1'b0;
    bus.byte_in  = 8'h00;
    bus.flush    = 1'b0;

    // Hand-computed expectations pinning the parser model.
    q = '{8'h8B, 8'h46, 8'hFE};
    chk_instr("pin_mov_bp", model_parse(q), mk(8'h8B, 8'h46, 16'hFFFE, 16'h0000, 1'b0, 3'b000, 1'b0, 4'd3));
    q = '{8'hF3, 8'h2E, 8'hA5};
    chk_instr("pin_rep_cs", model_parse(q), mk(8'hA5, 8'h00, 16'h0000, 16'h0000, 1'b1, 3'b101, 1'b0, 4'd3));
    q = '{8'hC7, 8'h06, 8'h34, 8'h12, 8'h78, 8'h56};
    chk_instr("pin_c7", model_parse(q), mk(8'hC7, 8'h06, 16'h1234, 16'h5678, 1'b0, 3'b000, 1'b0, 4'd6));
    q = '{8'h26, 8'h3E, 8'hC6, 8'h40, 8'h80, 8'hFF};
    chk_instr("pin_c6_sext", model_parse(q), mk(8'hC6, 8'h40, 16'hFF80, 16'hFFFF, 1'b0, 3'b111, 1'b0, 4'd6));

    repeat (3) @(negedge clk);
    chk("reset_outs", {bus.instr_vld, bus.opcode, bus.ilen, bus.rep, bus.sop_l, bus.off}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_rdy", {bus.byte_rdy, bus.instr_vld}, 64'b10);

    // Directed instructions with literal expectations.
    ack_mode = 1;
    q = '{8'h8B, 8'h46, 8'hFE};
    push_exp(q, mk(8'h8B, 8'h46, 16'hFFFE, 16'h0000, 1'b0, 3'b000, 1'b0, 4'd3));
    q = '{8'hF3, 8'h2E, 8'hA5};
    push_exp(q, mk(8'hA5, 8'h00, 16'h0000, 16'h0000, 1'b1, 3'b101, 1'b0, 4'd3));
    q = '{8'h90};
    push_exp(q, mk(8'h90, 8'h00, 16'h0000, 16'h0000, 1'b0, 3'b000, 1'b0, 4'd1));
    q = '{8'hC7, 8'h06, 8'h34, 8'h12, 8'h78, 8'h56};
    push_exp(q, mk(8'hC7, 8'h06, 16'h1234, 16'h5678, 1'b0, 3'b000, 1'b0, 4'd6));
`ifdef ZET_FETCH_LOCK_EN
    q = '{8'hF0, 8'h90};
    push_exp(q, mk(8'h90, 8'h00, 16'h0000, 16'h0000, 1'b0, 3'b000, 1'b1, 4'd2));
`else
    q = '{8'hF0};
    push_exp(q, mk(8'hF0, 8'h00, 16'h0000, 16'h0000, 1'b0, 3'b000, 1'b0, 4'd1));
    q = '{8'h90};
    push_exp(q, mk(8'h90, 8'h00, 16'h0000, 16'h0000, 1'b0, 3'b000, 1'b0, 4'd1));
`endif
    drain("drain_directed", 400);
    repeat (3) cycle();

    // Latency of a lone opcode byte: push edge, then opcode, S_MODRM, S_CHK.
    ack_mode = 2;
    exp_q.push_back(mk(8'h90, 8'h00, 16'h0000, 16'h0000, 1'b0, 3'b000, 1'b0, 4'd1));
    @(negedge clk);
    #2;
    bus.byte_vld = 1'b1;
    bus.byte_in  = 8'h90;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.instr_vld && n < 20);
    chk("latency", 64'(n), 64'd4);
    repeat (3) cycle();

    // Fill the FIFO behind a parked instruction.
    ack_mode = 0;
    for (int k = 0; k < 12; k++) begin
      q = '{8'h90};
      push_exp(q, mk(8'h90, 8'h00, 16'h0000, 16'h0000, 1'b0, 3'b000, 1'b0, 4'd1));
    end
    repeat (20) cycle();
    chk("full_rdy", 64'(bus.byte_rdy), 64'd0);
    chk("full_occ", 64'(tx_q.size()), 64'd3);
    ack_mode = 1;
    drain("drain_full", 400);

    // Flush in S_OFF0 with three bytes queued and a byte being offered.
    ack_mode = 0;
    q = '{8'h90};
    push_exp(q, mk(8'h90, 8'h00, 16'h0000, 16'h0000, 1'b0, 3'b000, 1'b0, 4'd1));
    tx_q.push_back(8'hC7); tx_q.push_back(8'h06);
    tx_q.push_back(8'h34); tx_q.push_back(8'h12); tx_q.push_back(8'h56);
    repeat (15) cycle();
    ack_mode = 2;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(bus.ilen == 4'd2 && !bus.instr_vld) && n < 40);
    chk("flush_setup", {60'd0, bus.ilen}, 64'd2);
    cycle();
    bus.flush    = 1'b1;
    bus.byte_vld = 1'b1;
    bus.byte_in  = 8'hEE;
    @(negedge clk);
    chk("flush_state", {bus.instr_vld, bus.ilen, bus.rep, bus.sop_l, bus.lock, bus.byte_rdy}, 64'b1);
    #2;
    bus.flush    = 1'b0;
    bus.byte_vld = 1'b0;
    repeat (10) cycle();
    chk("flush_quiet", 64'(bus.instr_vld), 64'd0);
    ack_mode = 1;
    q = '{8'h90};
    push_exp(q, mk(8'h90, 8'h00, 16'h0000, 16'h0000, 1'b0, 3'b000, 1'b0, 4'd1));
    drain("drain_flush", 200);

    // Randomized stream against the parser model.
    vld_pct = 70;
    for (int k = 0; k < 60; k++) gen_instr();
    drain("drain_random", 8000);
    repeat (5) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
